// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// alu_pkg: shared constants for the ALU result collector slice.
//   Unit codes tag every buffered result with its source unit.
//   Default widths match the ALU core this collector sits behind.
package alu_pkg;

    // Default parameterisation of the collector
    localparam int OP_DATA_WIDTH_DEF = 16;
    localparam int CMP_OUT_WIDTH_DEF = 2;
    localparam int FIFO_DEPTH_DEF    = 4;

    // Width of the unit tag carried in each FIFO entry
    localparam int UNIT_W = 2;

    // Source unit codes as seen on RES_UNIT
    localparam logic [UNIT_W-1:0] UNIT_ARITH = 2'b00;
    localparam logic [UNIT_W-1:0] UNIT_LOGIC = 2'b01;
    localparam logic [UNIT_W-1:0] UNIT_CMP   = 2'b10;
    localparam logic [UNIT_W-1:0] UNIT_SHIFT = 2'b11;

    // True when more than one bit of a strobe vector is set.
    // Clearing the lowest set bit leaves a non-zero value only if a second bit exists.
    function automatic logic more_than_one(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/alu_res_fifo.sv
`timescale 1ns/1ps
// alu_res_fifo: synchronous FIFO with a registered head word.
//   Latency: an entry pushed into an empty FIFO appears on head one cycle later.
//   Backpressure: push while full is ignored unless a pop happens in the same cycle.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   push, din       write request and data
//   pop             read request (ignored when empty)
//   head            registered copy of the oldest entry (held when empty)
//   full, empty     occupancy status
//   count           number of stored entries, one bit wider than the pointers
module alu_res_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign rd_next = rd_ptr + PTR_ONE;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept
    // a push when it is also being popped.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage needs no reset: only slots below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end

            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            // Head register tracks the entry that will be oldest after this edge.
            // When more than one entry remains after a pop, the successor is already
            // in memory (a same-cycle write lands in the slot being freed, never at
            // rd_next, since DEPTH >= 2). When the FIFO is or becomes empty before
            // the push lands, the incoming word itself becomes the head.
            if (do_pop && (count > CNT_ONE)) begin
                head <= mem[rd_next];
            end else if (do_push && (empty || (do_pop && (count == CNT_ONE)))) begin
                head <= din;
            end
        end
    end

endmodule

// File: rtl/alu_result_collector.sv
`timescale 1ns/1ps
// alu_result_collector: packs ALU unit results into tagged words and buffers them for the host.
//   Latency: a flag in cycle N reaches RES_VALID in cycle N+1 when the buffer was empty.
//   Backpressure: RES_READY low holds the head; a result arriving while full is dropped (OVF_ERR).
//
// Ports:
//   CLK, RST                         clock, asynchronous active-high reset
//   Arith_OUT/Carry_OUT/Arith_Flag   arithmetic result, carry, valid strobe
//   Logic_OUT/Logic_Flag             logic result and valid strobe
//   CMP_OUT/CMP_Flag                 compare result and valid strobe
//   Shift_OUT/Shift_Flag             shift result and valid strobe
//   RES_VALID/RES_READY              output handshake for the buffered head
//   RES_DATA/RES_UNIT/RES_CARRY      head word, source unit tag, arithmetic carry
//   ALMOST_FULL                      one slot or less left; issuer must pause
//   OVF_ERR, MULTI_ERR, ERR_CLR      sticky error flags and their clear
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int OP_DATA_WIDTH = OP_DATA_WIDTH_DEF,
    parameter int CMP_OUT_WIDTH = CMP_OUT_WIDTH_DEF,
    parameter int FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,

    input  logic [2*OP_DATA_WIDTH-1:0] Arith_OUT,
    input  logic                       Carry_OUT,
    input  logic                       Arith_Flag,
    input  logic [OP_DATA_WIDTH-1:0]   Logic_OUT,
    input  logic                       Logic_Flag,
    input  logic [CMP_OUT_WIDTH-1:0]   CMP_OUT,
    input  logic                       CMP_Flag,
    input  logic [OP_DATA_WIDTH-1:0]   Shift_OUT,
    input  logic                       Shift_Flag,

    output logic                       RES_VALID,
    input  logic                       RES_READY,
    output logic [2*OP_DATA_WIDTH-1:0] RES_DATA,
    output logic [1:0]                 RES_UNIT,
    output logic                       RES_CARRY,

    output logic                       ALMOST_FULL,
    output logic                       OVF_ERR,
    output logic                       MULTI_ERR,
    input  logic                       ERR_CLR
);

    localparam int RES_W   = 2 * OP_DATA_WIDTH;
    // Entry layout: {unit[1:0], carry, data[RES_W-1:0]}
    localparam int ENTRY_W = RES_W + UNIT_W + 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(FIFO_DEPTH - 1);

    logic [3:0]         flags;
    logic               any_flag;
    logic               multi_evt;
    logic               ovf_evt;
    logic               pop_req;

    logic [UNIT_W-1:0]  sel_unit;
    logic [RES_W-1:0]   sel_data;
    logic               sel_carry;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] entry_head;

    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    // Strobe vector ordered from highest to lowest priority.
    assign flags     = {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
    assign any_flag  = |flags;
    assign multi_evt = more_than_one(flags);

    // Priority select and packing. Only the arithmetic result is signed and
    // already full width; the others are zero-extended.
    always_comb begin
        sel_unit  = UNIT_ARITH;
        sel_data  = '0;
        sel_carry = 1'b0;
        if (Arith_Flag) begin
            sel_unit  = UNIT_ARITH;
            sel_data  = Arith_OUT;
            sel_carry = Carry_OUT;
        end else if (Logic_Flag) begin
            sel_unit  = UNIT_LOGIC;
            sel_data  = {{(RES_W-OP_DATA_WIDTH){1'b0}}, Logic_OUT};
        end else if (CMP_Flag) begin
            sel_unit  = UNIT_CMP;
            sel_data  = {{(RES_W-CMP_OUT_WIDTH){1'b0}}, CMP_OUT};
        end else if (Shift_Flag) begin
            sel_unit  = UNIT_SHIFT;
            sel_data  = {{(RES_W-OP_DATA_WIDTH){1'b0}}, Shift_OUT};
        end
    end

    assign entry_in = {sel_unit, sel_carry, sel_data};

    // Head is only valid once registered, so a push into an empty buffer
    // never coincides with a pop of that same entry.
    assign pop_req = RES_VALID && RES_READY;

    alu_res_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (any_flag),
        .din   (entry_in),
        .pop   (pop_req),
        .head  (entry_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign RES_VALID   = !fifo_empty;
    assign RES_DATA    = entry_head[RES_W-1:0];
    assign RES_CARRY   = entry_head[RES_W];
    assign RES_UNIT    = entry_head[ENTRY_W-1 -: UNIT_W];
    assign ALMOST_FULL = (fifo_count >= AF_LEVEL);

    // A drop only occurs when the slot cannot be freed by a same-cycle pop.
    assign ovf_evt = any_flag && fifo_full && !pop_req;

    // Sticky errors: a new event outranks a clear in the same cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVF_ERR   <= 1'b0;
            MULTI_ERR <= 1'b0;
        end else begin
            if (ovf_evt) begin
                OVF_ERR <= 1'b1;
            end else if (ERR_CLR) begin
                OVF_ERR <= 1'b0;
            end

            if (multi_evt) begin
                MULTI_ERR <= 1'b1;
            end else if (ERR_CLR) begin
                MULTI_ERR <= 1'b0;
            end
        end
    end

endmodule
